// File: rtl/uart_rx_edge_bit_sampler.sv
// uart_rx_edge_bit_sampler: oversampling edge/bit counters plus 2-of-3 mid-bit majority sampler; `RX_SYNC_EN adds a 2-flop RX_IN synchronizer
module uart_rx_edge_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int CNT_W      = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  enable,
    input  logic                  data_samp_en,
    output logic [CNT_W-1:0]      edge_cnt,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  sampled_bit,
    output logic                  samp_strobe
);
    localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

    logic [PRESCALE_W-1:0] r_p;
    logic                  r_en_d;
    logic                  r_s0;
    logic                  r_s1;
    logic                  w_rx;
    logic [PRESCALE_W-1:0] w_p_sel;
    logic [PRESCALE_W-1:0] w_h;
    logic [PRESCALE_W-1:0] w_edge;
    logic                  w_wrap;
    logic                  w_act;
    logic                  w_maj;

`ifdef RX_SYNC_EN
    logic [1:0] r_sync;

    // two-stage synchronizer, idles high like the line itself
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], RX_IN};
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    assign w_p_sel = (PRESCALE == P16 || PRESCALE == P32) ? PRESCALE : P8;
    assign w_h     = r_p >> 1;
    assign w_edge  = PRESCALE_W'(edge_cnt);
    assign w_wrap  = w_edge == r_p - ONE;
    assign w_act   = enable && data_samp_en;
    assign w_maj   = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

    // latch the oversampling ratio only when enable rises, so mid-frame PRESCALE changes are ignored
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_p    <= P8;
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (enable && !r_en_d) r_p <= w_p_sel;
        end
    end

    // edge counter wraps every P clocks and advances the saturating bit counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (w_wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= (&bit_cnt) ? bit_cnt : bit_cnt + 1'b1;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // capture samples at H-2 and H-1, vote with the live sample at H and pulse the strobe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            sampled_bit <= 1'b1;
            samp_strobe <= 1'b0;
        end else begin
            samp_strobe <= w_act && w_edge == w_h;
            if (w_act && w_edge == w_h - TWO) r_s0 <= w_rx;
            if (w_act && w_edge == w_h - ONE) r_s1 <= w_rx;
            if (w_act && w_edge == w_h) sampled_bit <= w_maj;
        end
    end
endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// tb_uart_rx_edge_bit_sampler: directed stimulus with a cycle-count based reference model and literal spot checks
module tb_uart_rx_edge_bit_sampler;
`ifdef RX_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clk = 0;
    logic       rst = 1;
    logic       rx_in = 1;
    logic [5:0] prescale = 6'd8;
    logic       en = 0;
    logic       dse = 0;
    logic [4:0] edge_cnt;
    logic [4:0] bit_cnt;
    logic       sampled_bit;
    logic       samp_strobe;

    int total = 0;
    int bad = 0;
    int n_str;
    int e_last;
    int sb_q[$];
    int b_q[$];
    int exp4[10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    logic [9:0] frame = {1'b1, 8'h5A, 1'b0};

    uart_rx_edge_bit_sampler dut (
        .CLK(clk), .RST(rst), .RX_IN(rx_in), .PRESCALE(prescale),
        .enable(en), .data_samp_en(dse),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .sampled_bit(sampled_bit), .samp_strobe(samp_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: counters derived from clocks elapsed since enable rose
    initial begin
        int   m_p, m_n, e, h;
        logic m_enp, m_sampled, m_strobe, m_h0, m_h1, rx;
        logic r_i, e_i, d_i, x_i;
        logic [5:0] p_i;
        logic m_seen[32];
        m_p = 8; m_n = 0; m_enp = 0; m_sampled = 1; m_strobe = 0; m_h0 = 1; m_h1 = 1;
        foreach (m_seen[i]) m_seen[i] = 1;
        forever begin
            @(posedge clk);
            r_i = rst; e_i = en; d_i = dse; x_i = rx_in; p_i = prescale;
            if (r_i) begin
                m_p = 8; m_n = 0; m_enp = 0; m_sampled = 1; m_strobe = 0; m_h0 = 1; m_h1 = 1;
                foreach (m_seen[i]) m_seen[i] = 1;
            end else begin
                if (L == 2) begin
                    rx = m_h1; m_h1 = m_h0; m_h0 = x_i;
                end else begin
                    rx = x_i;
                end
                if (e_i && !m_enp) m_p = (p_i == 16 || p_i == 32) ? int'(p_i) : 8;
                m_strobe = 0;
                if (!e_i) m_n = 0;
                else begin
                    e = m_n % m_p;
                    h = m_p / 2;
                    if (d_i) begin
                        m_seen[e] = rx;
                        if (e == h) begin
                            m_sampled = (int'(m_seen[h-2]) + int'(m_seen[h-1]) + int'(rx)) >= 2;
                            m_strobe = 1;
                        end
                    end
                    m_n++;
                end
                m_enp = e_i;
            end
            #1;
            chk("model edge_cnt", int'(edge_cnt), m_n % m_p);
            chk("model bit_cnt", int'(bit_cnt), (m_n / m_p > 31) ? 31 : m_n / m_p);
            chk("model sampled_bit", int'(sampled_bit), int'(m_sampled));
            chk("model samp_strobe", int'(samp_strobe), int'(m_strobe));
        end
    end

    task automatic cyc(input logic v);
        rx_in = v;
        @(posedge clk);
        #2;
        if (samp_strobe) begin
            n_str++;
            e_last = int'(edge_cnt);
            sb_q.push_back(int'(sampled_bit));
            b_q.push_back(int'(bit_cnt));
        end
    endtask

    task automatic clr_rec();
        n_str = 0; e_last = -1; sb_q.delete(); b_q.delete();
    endtask

    initial begin
        clr_rec();
        repeat (3) cyc(1);
        chk("reset edge_cnt", int'(edge_cnt), 0);
        chk("reset bit_cnt", int'(bit_cnt), 0);
        chk("reset sampled_bit", int'(sampled_bit), 1);
        chk("reset samp_strobe", int'(samp_strobe), 0);
        rst = 0;
        cyc(1);
        // basic counting at P=8
        en = 1; dse = 1;
        cyc(1);
        chk("t1 first edge", int'(edge_cnt), 1);
        repeat (6) cyc(1);
        chk("t1 edge7", int'(edge_cnt), 7);
        chk("t1 bit0", int'(bit_cnt), 0);
        cyc(1);
        chk("t1 wrap edge", int'(edge_cnt), 0);
        chk("t1 bit1", int'(bit_cnt), 1);
        repeat (8) cyc(1);
        chk("t1 bit2", int'(bit_cnt), 2);
        en = 0;
        cyc(1);
        chk("t1 clear bit", int'(bit_cnt), 0);
        // low on sample edges 2,3,4
        clr_rec(); en = 1;
        for (int k = 0; k < 8; k++) cyc(((k + L) % 8 >= 2 && (k + L) % 8 <= 4) ? 1'b0 : 1'b1);
        chk("t2 strobes", n_str, 1);
        chk("t2 strobe edge", e_last, 5);
        chk("t2 sampled", sb_q.size() > 0 ? sb_q[0] : -1, 0);
        en = 0;
        cyc(1);
        chk("t2 hold across disable", int'(sampled_bit), 0);
        // single glitch is outvoted; then sampling disabled holds value
        clr_rec(); en = 1;
        for (int k = 0; k < 8; k++) cyc(((k + L) % 8 == 3) ? 1'b0 : 1'b1);
        chk("t3 strobes", n_str, 1);
        chk("t3 sampled", int'(sampled_bit), 1);
        dse = 0;
        for (int k = 0; k < 8; k++) cyc(0);
        chk("t3 no strobe gated", n_str, 1);
        chk("t3 hold gated", int'(sampled_bit), 1);
        dse = 1; en = 0;
        cyc(1);
        // full 8N1 frame 0x5A at P=16
        clr_rec(); prescale = 6'd16; en = 1;
        for (int k = 0; k < 160; k++) cyc(frame[k / 16]);
        chk("t4 strobes", n_str, 10);
        chk("t4 strobe edge", e_last, 9);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4 bit%0d value", i), i < sb_q.size() ? sb_q[i] : -1, exp4[i]);
            chk($sformatf("t4 bit%0d index", i), i < b_q.size() ? b_q[i] : -1, i);
        end
        en = 0;
        cyc(1);
        // PRESCALE changes ignored mid-frame; unsupported value behaves as 8; 32 supported
        prescale = 6'd8; en = 1;
        repeat (4) cyc(1);
        prescale = 6'd16;
        repeat (12) cyc(1);
        chk("t5 midframe bit", int'(bit_cnt), 2);
        chk("t5 midframe edge", int'(edge_cnt), 0);
        en = 0; cyc(1);
        prescale = 6'd12; en = 1;
        repeat (16) cyc(1);
        chk("t5 p12 bit", int'(bit_cnt), 2);
        en = 0; cyc(1);
        prescale = 6'd32; en = 1;
        repeat (16) cyc(1);
        chk("t5 p32 edge", int'(edge_cnt), 16);
        chk("t5 p32 bit", int'(bit_cnt), 0);
        // bit counter saturates at 31
        en = 0; cyc(1);
        prescale = 6'd8; en = 1;
        repeat (270) cyc(1);
        chk("sat bit", int'(bit_cnt), 31);
        chk("sat edge", int'(edge_cnt), 6);
        // asynchronous reset mid-frame
        en = 0; cyc(1);
        en = 1;
        repeat (35) cyc(1);
        chk("t6 pre bit", int'(bit_cnt), 4);
        chk("t6 pre edge", int'(edge_cnt), 3);
        #1 rst = 1;
        #1;
        chk("t6 async edge", int'(edge_cnt), 0);
        chk("t6 async bit", int'(bit_cnt), 0);
        chk("t6 async strobe", int'(samp_strobe), 0);
        chk("t6 async sampled", int'(sampled_bit), 1);
        cyc(1);
        rst = 0;
        cyc(1);
        chk("t6 restart edge", int'(edge_cnt), 1);
        chk("t6 restart bit", int'(bit_cnt), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
